// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN core: handshake FSM encodings
// used by the spike input queue and the network controller.
package snn_pkg;

    localparam int unsigned SR_DEPTH_DEFAULT       = 16384;
    localparam int unsigned NR_DEPTH_DEFAULT       = 1024;
    localparam int unsigned FIFO_DEPTH_DEFAULT     = 16;
    localparam int unsigned DROP_CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        Q_IDLE    = 2'd0,
        Q_PRESENT = 2'd1,
        Q_GAP     = 2'd2
    } q_state_t;

    typedef enum logic [1:0] {
        C_IDLE        = 2'd0,
        C_PROC_NEURON = 2'd1,
        C_PROC_INPUT  = 2'd2
    } c_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read, synchronous reset and flush.
// Push while full and pop while empty are ignored; flush wins over both.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW + 1)'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Full/empty come from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/spike_input_queue.sv
// Buffers non-stallable spike strobes and presents them one at a time to the
// network controller, holding each index until acked, with a gap cycle between events.
module spike_input_queue
    import snn_pkg::*;
#(
    parameter int unsigned SR_DEPTH       = SR_DEPTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int unsigned DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    input  logic [$clog2(SR_DEPTH)-1:0]   ev_index,
    input  logic                          flush,
    output logic                          input_occurred,
    output logic [$clog2(SR_DEPTH)-1:0]   input_index,
    input  logic                          input_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          full,
    output logic                          empty,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

    localparam int unsigned IW = $clog2(SR_DEPTH);

    q_state_t                  state_q, state_d;
    logic                      occurred_q, occurred_d;
    logic [IW-1:0]             index_q, index_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic                      fifo_pop;
    logic [IW-1:0]             fifo_rdata;
    logic                      fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (ev_valid),
        .pop   (fifo_pop),
        .wdata (ev_index),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A strobe lost to a flush is intentional, so it is not counted as a drop.
    always_comb begin
        drop_count_d = drop_count_q;
        if (ev_valid && fifo_full && !flush && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        occurred_d = occurred_q;
        index_d    = index_q;
        fifo_pop   = 1'b0;
        case (state_q)
            Q_IDLE: begin
                if (!fifo_empty && !flush) begin
                    fifo_pop   = 1'b1;
                    index_d    = fifo_rdata;
                    occurred_d = 1'b1;
                    state_d    = Q_PRESENT;
                end
            end
            Q_PRESENT: begin
                // A presented event may already be sampled, so flush leaves it alone.
                if (input_ack) begin
                    occurred_d = 1'b0;
                    state_d    = Q_GAP;
                end
            end
            Q_GAP: begin
                occurred_d = 1'b0;
                state_d    = Q_IDLE;
            end
            default: begin
                occurred_d = 1'b0;
                state_d    = Q_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= Q_IDLE;
            occurred_q   <= 1'b0;
            index_q      <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            occurred_q   <= occurred_d;
            index_q      <= index_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign input_occurred = occurred_q;
    assign input_index    = index_q;
    assign full           = fifo_full;
    assign empty          = fifo_empty;
    assign drop_count     = drop_count_q;

endmodule
